// File: rtl/cw_msg_packer.sv
// Packs the constant-weight decoder's serial message LSB-first into words and
// queues them in a small dual-write FIFO with a valid/ready output port.
module cw_msg_packer #(
  parameter int WORD_W = 8,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      bin_msg,
  input  logic                      msg_rdy,
  input  logic                      msg_done,
  output logic [WORD_W-1:0]         out_word,
  output logic [$clog2(WORD_W):0]   out_nbits,
  output logic                      out_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CNT_W-1:0]          msg_bits,
  output logic                      overflow
);

  localparam int NB_W = $clog2(WORD_W) + 1;
  localparam int IX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = PW + 1;
  localparam logic [NB_W-1:0] FULL    = NB_W'(WORD_W);
  localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);

  logic [WORD_W-1:0] acc_q, acc_d;
  logic [NB_W-1:0]   fill_q, fill_d;
  logic [CNT_W-1:0]  msgBits_q, msgBits_d;
  logic              msgEnded_q, msgEnded_d;
  logic              overflow_q;

  logic [WORD_W-1:0] memWord_q  [DEPTH];
  logic [NB_W-1:0]   memNbits_q [DEPTH];
  logic              memLast_q  [DEPTH];
  logic [PW-1:0]     wrPtr_q, rdPtr_q, wrPtr1;
  logic [CW-1:0]     count_q, occAfterPop, count_d;

  logic              fullPush, donePush, accept0, accept1, pop;
  logic [WORD_W-1:0] fullWord, doneWord;
  logic [NB_W-1:0]   doneNbits;

  // A full word waits for the next bit or msg_done so its last flag is known.
  always_comb begin
    acc_d      = acc_q;
    fill_d     = fill_q;
    msgBits_d  = msgBits_q;
    msgEnded_d = msgEnded_q;
    fullPush   = 1'b0;
    fullWord   = acc_q;
    donePush   = 1'b0;
    doneWord   = '0;
    doneNbits  = '0;
    if (msg_rdy) begin
      if (fill_q == FULL) begin
        fullPush = 1'b1;
        acc_d    = '0;
        acc_d[0] = bin_msg;
        fill_d   = NB_W'(1);
      end else begin
        acc_d[fill_q[IX_W-1:0]] = bin_msg;
        fill_d = fill_q + NB_W'(1);
      end
      if (msgEnded_q)
        msgBits_d = CNT_W'(1);
      else if (msgBits_q != '1)
        msgBits_d = msgBits_q + CNT_W'(1);
      msgEnded_d = 1'b0;
    end
    if (msg_done) begin
      donePush   = 1'b1;
      doneWord   = acc_d;
      doneNbits  = fill_d;
      acc_d      = '0;
      fill_d     = '0;
      msgEnded_d = 1'b1;
    end
  end

  // Each of the two possible writes is checked against space left after the pop.
  always_comb begin
    pop         = (count_q != '0) && out_ready;
    occAfterPop = count_q - CW'(pop);
    accept0     = fullPush && (occAfterPop < DEPTH_C);
    accept1     = donePush && ((occAfterPop + CW'(accept0)) < DEPTH_C);
    count_d     = occAfterPop + CW'(accept0) + CW'(accept1);
    wrPtr1      = wrPtr_q + PW'(accept0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q      <= '0;
      fill_q     <= '0;
      msgBits_q  <= '0;
      msgEnded_q <= 1'b1;
      overflow_q <= 1'b0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        memWord_q[i]  <= '0;
        memNbits_q[i] <= '0;
        memLast_q[i]  <= 1'b0;
      end
    end else begin
      acc_q      <= acc_d;
      fill_q     <= fill_d;
      msgBits_q  <= msgBits_d;
      msgEnded_q <= msgEnded_d;
      if ((fullPush && !accept0) || (donePush && !accept1))
        overflow_q <= 1'b1;
      if (accept0) begin
        memWord_q[wrPtr_q]  <= fullWord;
        memNbits_q[wrPtr_q] <= FULL;
        memLast_q[wrPtr_q]  <= 1'b0;
      end
      if (accept1) begin
        memWord_q[wrPtr1]  <= doneWord;
        memNbits_q[wrPtr1] <= doneNbits;
        memLast_q[wrPtr1]  <= 1'b1;
      end
      wrPtr_q <= wrPtr_q + PW'(accept0) + PW'(accept1);
      rdPtr_q <= rdPtr_q + PW'(pop);
      count_q <= count_d;
    end
  end

  assign out_valid = (count_q != '0);
  assign out_word  = memWord_q[rdPtr_q];
  assign out_nbits = memNbits_q[rdPtr_q];
  assign out_last  = memLast_q[rdPtr_q];
  assign msg_bits  = msgBits_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_cw_msg_packer.sv
// Randomised and directed bench for cw_msg_packer: a message-level reference
// model feeds a scoreboard that an independent negedge monitor drains.
module tb_cw_msg_packer;

  localparam int WORD_W = 8;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              bin_msg = 1'b0;
  logic              msg_rdy = 1'b0;
  logic              msg_done = 1'b0;
  logic              out_ready = 1'b0;
  logic [WORD_W-1:0] out_word;
  logic [3:0]        out_nbits;
  logic              out_last;
  logic              out_valid;
  logic [CNT_W-1:0]  msg_bits;
  logic              overflow;

  cw_msg_packer #(.WORD_W(WORD_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .bin_msg(bin_msg), .msg_rdy(msg_rdy),
    .msg_done(msg_done), .out_word(out_word), .out_nbits(out_nbits),
    .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
    .msg_bits(msg_bits), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] word;
    logic [3:0] nbits;
    logic       last;
  } exp_t;

  exp_t     expQ[$];
  bit       pend[$];
  int       modelOcc = 0;
  bit       modelOvf = 1'b0;
  int       modelBits = 0;
  bit       modelEnded = 1'b1;
  int       popCount = 0;
  int       nChecks = 0;
  int       nPass = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual === expected) nPass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
  endtask

  // The model sees messages as bit lists: a word is offered to the FIFO once
  // eight bits are pending and another arrives, or when the message ends.
  task automatic emitWord(input bit last);
    exp_t e;
    e.word = '0;
    for (int i = 0; i < pend.size(); i++) e.word[i] = pend[i];
    e.nbits = 4'(pend.size());
    e.last  = last;
    if (modelOcc < DEPTH) begin
      modelOcc++;
      expQ.push_back(e);
    end else begin
      modelOvf = 1'b1;
    end
    pend.delete();
  endtask

  always @(posedge clk) begin
    if (rst) begin
      pend.delete();
      expQ.delete();
      modelOcc   = 0;
      modelOvf   = 1'b0;
      modelBits  = 0;
      modelEnded = 1'b1;
    end else begin
      if (modelOcc > 0 && out_ready) modelOcc--;
      if (msg_rdy) begin
        if (pend.size() == WORD_W) emitWord(1'b0);
        pend.push_back(bin_msg);
        if (modelEnded) modelBits = 1;
        else if (modelBits < (1 << CNT_W) - 1) modelBits++;
        modelEnded = 1'b0;
      end
      if (msg_done) begin
        emitWord(1'b1);
        modelEnded = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    checkOutput("out_valid", 32'(out_valid), 32'(modelOcc != 0));
    if (out_valid) begin
      checkOutput("sb_has_entry", 32'(expQ.size() != 0), 32'd1);
      if (expQ.size() != 0) begin
        checkOutput("out_word", 32'(out_word), 32'(expQ[0].word));
        checkOutput("out_nbits", 32'(out_nbits), 32'(expQ[0].nbits));
        checkOutput("out_last", 32'(out_last), 32'(expQ[0].last));
        if (out_ready) begin
          void'(expQ.pop_front());
          popCount++;
        end
      end
    end
    checkOutput("overflow", 32'(overflow), 32'(modelOvf));
    checkOutput("msg_bits", 32'(msg_bits), 32'(modelBits));
  end

  task automatic applyStimulus(input logic rdy, input logic b, input logic done, input logic ready);
    @(posedge clk);
    #2;
    msg_rdy   = rdy;
    bin_msg   = b;
    msg_done  = done;
    out_ready = ready;
  endtask

  task automatic resetDut();
    @(posedge clk);
    #2;
    rst = 1'b1; msg_rdy = 1'b0; msg_done = 1'b0; bin_msg = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic drain(input string name, input int maxCycles);
    bit done;
    done = 1'b0;
    for (int i = 0; i < maxCycles && !done; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      if (modelOcc == 0 && expQ.size() == 0 && !out_valid) done = 1'b1;
    end
    checkOutput({name, "_drain_timeout"}, 32'(done), 32'd1);
  endtask

  int startPops;

  initial begin
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    checkOutput("rst_out_word", 32'(out_word), 32'd0);
    checkOutput("rst_out_nbits", 32'(out_nbits), 32'd0);
    checkOutput("rst_out_last", 32'(out_last), 32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);

    // alternating bits, done on the 20th
    startPops = popCount;
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'(i % 2 == 0), 1'(i == 19), 1'b1);
    drain("t1", 50);
    checkOutput("t1_words", 32'(popCount - startPops), 32'd3);
    checkOutput("t1_msg_bits", 32'(msg_bits), 32'd20);
    checkOutput("t1_overflow", 32'(overflow), 32'd0);

    // 16 ones, done one cycle later
    startPops = popCount;
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    drain("t2", 50);
    checkOutput("t2_words", 32'(popCount - startPops), 32'd2);

    // empty message
    resetDut();
    startPops = popCount;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    drain("t3", 50);
    checkOutput("t3_words", 32'(popCount - startPops), 32'd1);
    checkOutput("t3_msg_bits", 32'(msg_bits), 32'd0);

    // overflow with stalled consumer
    resetDut();
    for (int i = 0; i < 48; i++) begin
      applyStimulus(1'b1, 1'b1, 1'(i == 47), 1'b0);
      if (i == 40) checkOutput("t4_ovf_before", 32'(overflow), 32'd0);
      if (i == 41) checkOutput("t4_ovf_after", 32'(overflow), 32'd1);
    end
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("t4_valid_held", 32'(out_valid), 32'd1);
    startPops = popCount;
    drain("t4", 50);
    checkOutput("t4_words", 32'(popCount - startPops), 32'd4);
    checkOutput("t4_ovf_sticky", 32'(overflow), 32'd1);

    // reset mid-message discards partial state
    resetDut();
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    resetDut();
    startPops = popCount;
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'(i < 4), 1'(i == 7), 1'b1);
    drain("t5", 50);
    checkOutput("t5_words", 32'(popCount - startPops), 32'd1);

    // pop and push together at full
    resetDut();
    for (int i = 0; i < 40; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("t6_overflow", 32'(overflow), 32'd0);
    checkOutput("t6_valid", 32'(out_valid), 32'd1);
    startPops = popCount;
    drain("t6", 50);
    checkOutput("t6_words", 32'(popCount - startPops), 32'd4);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    drain("t6b", 50);

    // random traffic
    resetDut();
    for (int i = 0; i < 600; i++)
      applyStimulus(1'($urandom_range(2) != 0), 1'($urandom_range(1)),
                    1'($urandom_range(11) == 0), 1'($urandom_range(3) != 0));
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    drain("rand", 100);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/cw_msg_packer.md
Name: cw_msg_packer

Overview:
- Downstream of the 10-38 constant-weight decoder.
- Collects the decoder's serial binary message (bin_msg qualified by msg_rdy, terminated by msg_done) and packs it LSB-first into WORD_W-bit words.
- Buffers the words in a small FIFO and presents them on a valid/ready output port, marking the final, possibly partial, word of each message.

Parameters:
- WORD_W, 8, width of packed output word
- DEPTH, 4, output FIFO depth in words (power of 2, >=2)
- CNT_W, 16, width of per-message bit counter

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- bin_msg  in  1  serial message bit from decoder
- msg_rdy  in  1  bin_msg valid this cycle
- msg_done  in  1  one-cycle pulse, message complete; may coincide with the final msg_rdy
- out_word  out  WORD_W  packed word at FIFO head
- out_nbits  out  log2(WORD_W)+1  valid bits in out_word (1..WORD_W; 0 only for an empty message)
- out_last  out  1  out_word is the final word of its message
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts the head word when out_valid&&out_ready
- msg_bits  out  CNT_W  bits received in current/last message
- overflow  out  1  sticky: a word was dropped because the FIFO was full

Behaviour:
- Reset (rst=1 at a clock edge): accumulator, fill count, FIFO pointers, msg_bits and overflow clear. out_valid=0, out_word=0, out_nbits=0, out_last=0. Reset mid-message discards all partial state; no word is emitted.
- Accumulator: WORD_W-bit register plus fill count 0..WORD_W.
  - On msg_rdy with fill<WORD_W: bit written at index fill; fill+1.
  - On msg_rdy with fill==WORD_W: the held full word is pushed with last=0, nbits=WORD_W. The accumulator restarts with the new bit at index 0, fill=1, other bits zero.
  - Consequence: a full word is held until the next bit or msg_done, so out_last can always be attached.
- msg_done:
  - If coincident with msg_rdy, the bit is absorbed first, applying the fill==WORD_W rule above. That can push two words in one cycle; the FIFO supports 2 writes per cycle, and each write independently obeys the full rule below.
  - Then the accumulator is pushed with last=1 and nbits=fill, unused bits zero. Fill returns to 0.
  - Empty message (fill==0, no bits since the previous done/reset): a single word 0 with nbits=0, last=1 is pushed.
- msg_bits increments on each msg_rdy. It saturates at all-ones, holds its value after msg_done, and clears on the first msg_rdy of the next message.
- Latency: a pushed word is visible at out_* on the cycle after the push edge.
- FIFO:
  - Registered head outputs, pointer wrap modulo DEPTH.
  - Pop occurs on out_valid&&out_ready.
  - Push is accepted if the occupancy after this cycle's pop is < DEPTH; a pop and a push at full both succeed.
  - A push refused at full drops that word and sets overflow=1, which stays set until rst. Accumulator behaviour is unaffected.
- msg_rdy without msg_done after msg_done: starts a new message. msg_done pulses on consecutive cycles give an empty message for the second pulse.
- out_word, out_nbits and out_last must hold stable while out_valid&&!out_ready.

Test Plan:
(all with WORD_W=8, DEPTH=4)
1. out_ready=1; 20 bits 1,0,1,0,... with msg_done on the 20th bit:
   - required outputs, in order: 0x55/8/last0, 0x55/8/last0, 0x05/4/last1
   - msg_bits=20, overflow=0
2. 16 bits all 1, msg_done one cycle after the last bit -> 0xFF/8/last0, then 0xFF/8/last1; no extra empty word.
3. msg_done with no prior bits -> exactly one word 0x00/nbits0/last1; msg_bits=0.
4. out_ready=0; 48 bits of 1, then msg_done:
   - overflow=1 from the 5th push (the 41st bit); out_valid stays 1.
   - Raising out_ready drains exactly four 0xFF/8/last0 words, then out_valid=0.
   - overflow stays 1 until rst.
5. Five bits, then rst for one cycle, then 8 bits 1,1,1,1,0,0,0,0 plus msg_done:
   - nothing from the aborted message appears
   - single output 0x0F/8/last1
6. FIFO full with out_ready=1, and a push in the same cycle -> head pops, new word enqueued, occupancy stays 4, overflow=0.
